segment_count_decoder: RTL and testbench

Read-back monitor for the two-digit seven-segment display path: samples the two 7-bit segment buses driven to the display, waits for them to hold steady, and decodes them back into the 8-bit hex count they represent. It sits beside the display encoder in self-test builds and in the segment-check top level. It reports a validated byte with a one-cycle strobe and flags segment patterns that are not legal hex glyphs.

---
 rtl/seg_decode_pkg.sv | 30 +++
 rtl/seg7_to_hex.sv | 35 +++
 rtl/segment_count_decoder.sv | 111 +++++++++++
 tb/tb_segment_count_decoder.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/seg_decode_pkg.sv
// Shared constants for the seven-segment read-back monitor: glyph patterns
// (bit 6 = segment A ... bit 0 = segment G, active-high) and FSM states.
package seg_decode_pkg;

  localparam int SEG_W = 7;

  localparam logic [SEG_W-1:0] GLYPH_0 = 7'h7E;
  localparam logic [SEG_W-1:0] GLYPH_1 = 7'h30;
  localparam logic [SEG_W-1:0] GLYPH_2 = 7'h6D;
  localparam logic [SEG_W-1:0] GLYPH_3 = 7'h79;
  localparam logic [SEG_W-1:0] GLYPH_4 = 7'h33;
  localparam logic [SEG_W-1:0] GLYPH_5 = 7'h5B;
  localparam logic [SEG_W-1:0] GLYPH_6 = 7'h5F;
  localparam logic [SEG_W-1:0] GLYPH_7 = 7'h70;
  localparam logic [SEG_W-1:0] GLYPH_8 = 7'h7F;
  localparam logic [SEG_W-1:0] GLYPH_9 = 7'h7B;
  localparam logic [SEG_W-1:0] GLYPH_A = 7'h77;
  localparam logic [SEG_W-1:0] GLYPH_B = 7'h1F;
  localparam logic [SEG_W-1:0] GLYPH_C = 7'h4E;
  localparam logic [SEG_W-1:0] GLYPH_D = 7'h3D;
  localparam logic [SEG_W-1:0] GLYPH_E = 7'h4F;
  localparam logic [SEG_W-1:0] GLYPH_F = 7'h47;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    STABLE
  } state_t;

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational inverse of the hex glyph table: segment pattern in,
// nibble plus a flag saying whether the pattern is a legal glyph.
module seg7_to_hex
  import seg_decode_pkg::*;
(
  input  logic [SEG_W-1:0] seg,
  output logic [3:0]       nib,
  output logic             legal
);

  always_comb begin
    nib   = 4'h0;
    legal = 1'b1;
    case (seg)
      GLYPH_0: nib = 4'h0;
      GLYPH_1: nib = 4'h1;
      GLYPH_2: nib = 4'h2;
      GLYPH_3: nib = 4'h3;
      GLYPH_4: nib = 4'h4;
      GLYPH_5: nib = 4'h5;
      GLYPH_6: nib = 4'h6;
      GLYPH_7: nib = 4'h7;
      GLYPH_8: nib = 4'h8;
      GLYPH_9: nib = 4'h9;
      GLYPH_A: nib = 4'hA;
      GLYPH_B: nib = 4'hB;
      GLYPH_C: nib = 4'hC;
      GLYPH_D: nib = 4'hD;
      GLYPH_E: nib = 4'hE;
      GLYPH_F: nib = 4'hF;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/segment_count_decoder.sv
// Two-digit seven-segment read-back: waits for the buses to settle, then decodes
// them to a byte. Define SEG_INPUT_ACTIVE_LOW_EN for active-low segment pins.
module segment_count_decoder
  import seg_decode_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic             i_Clk,
  input  logic             i_Rst_L,
  input  logic [SEG_W-1:0] i_Segment1,
  input  logic [SEG_W-1:0] i_Segment2,
  output logic [7:0]       o_Count,
  output logic             o_Count_DV,
  output logic             o_Error,
  output logic [7:0]       o_Err_Cnt
);

  localparam int              CNT_W   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  logic [2*SEG_W-1:0] seg_in;
  logic [2*SEG_W-1:0] r_Seg;
  logic [CNT_W-1:0]   r_Cnt;
  logic [CNT_W-1:0]   cnt_next;
  state_t             state;
  state_t             state_next;
  logic               match;
  logic               report;
  logic               fault;
  logic [3:0]         nib1;
  logic [3:0]         nib2;
  logic               legal1;
  logic               legal2;

`ifdef SEG_INPUT_ACTIVE_LOW_EN
  assign seg_in = ~{i_Segment1, i_Segment2};
`else
  assign seg_in = {i_Segment1, i_Segment2};
`endif

  assign match = (seg_in == r_Seg);

  // Decode the captured copy; at the decide edge it equals the live inputs.
  seg7_to_hex u_digit1 (.seg(r_Seg[2*SEG_W-1:SEG_W]), .nib(nib1), .legal(legal1));
  seg7_to_hex u_digit2 (.seg(r_Seg[SEG_W-1:0]),       .nib(nib2), .legal(legal2));

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = r_Cnt;
    report     = 1'b0;
    fault      = 1'b0;
    case (state)
      IDLE: begin
        state_next = SETTLE;
        cnt_next   = '0;
      end
      SETTLE: begin
        if (!match) begin
          cnt_next = '0;
        end else if (r_Cnt == CNT_MAX) begin
          state_next = STABLE;
          report     = legal1 && legal2;
          fault      = !(legal1 && legal2);
        end else begin
          cnt_next = r_Cnt + 1'b1;
        end
      end
      STABLE: begin
        if (!match) begin
          state_next = SETTLE;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_Seg      <= '0;
      r_Cnt      <= '0;
      o_Count    <= 8'h00;
      o_Count_DV <= 1'b0;
      o_Error    <= 1'b0;
      o_Err_Cnt  <= 8'h00;
    end else begin
      r_Seg      <= seg_in;
      r_Cnt      <= cnt_next;
      o_Count_DV <= report;
      o_Error    <= fault;
      if (report) begin
        o_Count <= {nib1, nib2};
      end
      if (fault && (o_Err_Cnt != 8'hFF)) begin
        o_Err_Cnt <= o_Err_Cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_segment_count_decoder.sv
// Bench for segment_count_decoder: vector table, corner sequences and random
// windows, all checked each cycle against a hold-time reference model.
module tb_segment_count_decoder;

  localparam int S = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] seg1;
  logic [6:0] seg2;
  logic [7:0] o_Count;
  logic       o_Count_DV;
  logic       o_Error;
  logic [7:0] o_Err_Cnt;

  always #5 clk = ~clk;

  segment_count_decoder #(.STABLE_CYCLES(S)) dut (
    .i_Clk      (clk),
    .i_Rst_L    (rst_n),
    .i_Segment1 (seg1),
    .i_Segment2 (seg2),
    .o_Count    (o_Count),
    .o_Count_DV (o_Count_DV),
    .o_Error    (o_Error),
    .o_Err_Cnt  (o_Err_Cnt)
  );

  localparam logic [6:0] GLY [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                      7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  typedef struct {
    logic [6:0] s1;
    logic [6:0] s2;
    logic [7:0] exp_count;
    logic       exp_err;
  } vec_t;

  int n_pass = 0;
  int n_total = 0;
  int dv_seen;
  int err_seen;

  // Reference model: counts edges the pair has been held unchanged.
  bit          fresh;
  int          held;
  logic [13:0] prev;
  logic [7:0]  m_count;
  logic [7:0]  m_errcnt;
  logic        m_dv;
  logic        m_err;

  function automatic logic [6:0] enc(input logic [6:0] g);
`ifdef SEG_INPUT_ACTIVE_LOW_EN
    return ~g;
`else
    return g;
`endif
  endfunction

  function automatic int glyph_idx(input logic [6:0] g);
    for (int i = 0; i < 16; i++) if (GLY[i] == g) return i;
    return -1;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h required %h at %0t", name, got, exp, $time);
  endtask

  task automatic model_reset();
    fresh = 1'b1; held = 0; prev = '0;
    m_count = 8'h00; m_errcnt = 8'h00; m_dv = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_edge(input logic [13:0] x);
    int i1;
    int i2;
    m_dv = 1'b0;
    m_err = 1'b0;
    if (fresh) begin held = 0; fresh = 1'b0; end
    else if (x != prev) held = 0;
    else held++;
    prev = x;
    if (held == S + 1) begin
      i1 = glyph_idx(x[13:7]);
      i2 = glyph_idx(x[6:0]);
      if (i1 >= 0 && i2 >= 0) begin
        m_count = {i1[3:0], i2[3:0]};
        m_dv = 1'b1;
      end else begin
        m_err = 1'b1;
        if (m_errcnt != 8'hFF) m_errcnt++;
      end
    end
  endtask

  task automatic cycle(input logic [6:0] a, input logic [6:0] b);
    seg1 = enc(a);
    seg2 = enc(b);
    @(posedge clk);
    model_edge({a, b});
    #1;
    check("cycle", {o_Count, o_Count_DV, o_Error, o_Err_Cnt}, {m_count, m_dv, m_err, m_errcnt});
    if (o_Count_DV) dv_seen++;
    if (o_Error) err_seen++;
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {o_Count, o_Count_DV, o_Error, o_Err_Cnt}, 32'h0);
  endtask

  vec_t tbl [11];

  initial begin
    tbl[0]  = '{7'h7E, 7'h30, 8'h01, 1'b0};
    tbl[1]  = '{7'h5B, 7'h47, 8'h5F, 1'b0};
    tbl[2]  = '{7'h7F, 7'h00, 8'h5F, 1'b1};
    tbl[3]  = '{7'h77, 7'h1F, 8'hAB, 1'b0};
    tbl[4]  = '{7'h4E, 7'h3D, 8'hCD, 1'b0};
    tbl[5]  = '{7'h4F, 7'h47, 8'hEF, 1'b0};
    tbl[6]  = '{7'h7E, 7'h79, 8'h03, 1'b0};
    tbl[7]  = '{7'h00, 7'h30, 8'h03, 1'b1};
    tbl[8]  = '{7'h33, 7'h70, 8'h47, 1'b0};
    tbl[9]  = '{7'h7F, 7'h7B, 8'h89, 1'b0};
    tbl[10] = '{7'h6D, 7'h5F, 8'h26, 1'b0};

    rst_n = 1'b0;
    seg1 = enc(7'h7E);
    seg2 = enc(7'h30);
    model_reset();
    dv_seen = 0;
    err_seen = 0;
    #1;
    check_reset_outputs("reset_state");
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset_held");
    rst_n = 1'b1;

    // Table: each entry held long enough for one report and a quiet tail.
    foreach (tbl[k]) begin
      dv_seen = 0;
      err_seen = 0;
      repeat (S + 6) cycle(tbl[k].s1, tbl[k].s2);
      check("tbl_count", {24'h0, o_Count}, {24'h0, tbl[k].exp_count});
      check("tbl_pulses", {dv_seen[15:0], err_seen[15:0]},
            tbl[k].exp_err ? {16'd0, 16'd1} : {16'd1, 16'd0});
    end

    // One-cycle glitch restarts the window.
    dv_seen = 0;
    err_seen = 0;
    repeat (3) cycle(7'h5B, 7'h47);
    cycle(7'h5B, 7'h4E);
    check("glitch_no_early_dv", dv_seen, 0);
    repeat (S + 6) cycle(7'h5B, 7'h47);
    check("glitch_count", {24'h0, o_Count}, 32'h5F);
    check("glitch_one_dv", dv_seen, 1);

    // Input change on the decide edge suppresses the report.
    dv_seen = 0;
    err_seen = 0;
    repeat (S + 1) cycle(7'h77, 7'h1F);
    cycle(7'h4E, 7'h3D);
    check("decide_edge_no_report", {24'h0, o_Count}, 32'h5F);
    check("decide_edge_no_pulse", dv_seen + err_seen, 0);
    repeat (S + 5) cycle(7'h4E, 7'h3D);
    check("decide_edge_later", {24'h0, o_Count}, 32'hCD);
    check("decide_edge_one_dv", dv_seen, 1);

    // Reset mid-window aborts; the same value reports after a full window.
    repeat (4) cycle(7'h7E, 7'h79);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset_async");
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("midreset_held");
    rst_n = 1'b1;
    dv_seen = 0;
    err_seen = 0;
    repeat (S + 6) cycle(7'h7E, 7'h79);
    check("midreset_count", {24'h0, o_Count}, 32'h03);
    check("midreset_one_dv", dv_seen, 1);

    // Random windows of legal and illegal pairs with random hold times.
    for (int w = 0; w < 80; w++) begin
      logic [6:0] a;
      logic [6:0] b;
      int hold;
      a = ($urandom_range(9) == 0) ? 7'($urandom) : GLY[$urandom_range(15)];
      b = ($urandom_range(9) == 0) ? 7'($urandom) : GLY[$urandom_range(15)];
      hold = $urandom_range(S + 4, 1);
      repeat (hold) cycle(a, b);
    end

    // Error counter saturation over 256 illegal windows.
    for (int w = 0; w < 257; w++) begin
      repeat (S + 2) cycle((w % 2 == 0) ? 7'h00 : 7'h01, 7'h30);
    end
    check("err_cnt_saturated", {24'h0, o_Err_Cnt}, 32'hFF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
